pad_io_bank: RTL and testbench

- Parametrised core-side logic for a bank of chip I/O pads. It sits between the sg13g2 pad cells (IOPadIn p2c, IOPadOut c2p, IOPadInOut c2p/c2p_en/p2c) and the user design.
- Every pad input passes through a synchroniser and a debounce filter.
- Dedicated outputs are registered, with four selectable modes: pass-through, loopback, counter and hold.
- Bidirectional pads get software-controlled data and output enable.
- Sticky rising-edge flags on the inputs drive an interrupt.

---
 rtl/pad_io_bank.sv | 169 ++++++++++++++++
 tb/tb_pad_io_bank.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_io_bank.sv
// Core-side logic for a bank of sg13g2 I/O pads: synchronised and debounced inputs, a moded
// output register, software-driven bidirectional pads and sticky rising-edge interrupt flags.
module pad_io_bank #(
    parameter int unsigned WIDTH       = 14,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [WIDTH-1:0] cfg_wdata,
    output logic [WIDTH-1:0] cfg_rdata,
    input  logic [WIDTH-1:0] in_p2c_i,
    output logic [WIDTH-1:0] out_c2p_o,
    input  logic [WIDTH-1:0] io_p2c_i,
    output logic [WIDTH-1:0] io_c2p_o,
    output logic [WIDTH-1:0] io_oe_o,
    output logic [WIDTH-1:0] edge_o,
    output logic             irq_o
);

    localparam int unsigned      CNT_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    localparam logic [1:0] ADDR_MODE   = 2'd0;
    localparam logic [1:0] ADDR_OE     = 2'd1;
    localparam logic [1:0] ADDR_IODATA = 2'd2;
    localparam logic [1:0] ADDR_EDGE   = 2'd3;

    // Group 0 is the dedicated input pads, group 1 the inout pads.
    localparam int GRP_IN = 0;
    localparam int GRP_IO = 1;

    typedef enum logic [1:0] {
        ModePass  = 2'd0,
        ModeLoop  = 2'd1,
        ModeCount = 2'd2,
        ModeHold  = 2'd3
    } mode_e;

    logic [WIDTH-1:0] pad_raw [2];
    logic [WIDTH-1:0] sync_q  [2][SYNC_STAGES];
    logic [WIDTH-1:0] filt_q  [2];
    logic [WIDTH-1:0] filt_d  [2];
    logic [CNT_W-1:0] cnt_q   [2][WIDTH];
    logic [CNT_W-1:0] cnt_d   [2][WIDTH];

    logic [WIDTH-1:0] filt_prev_q;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] edge_clr, edge_rise;
    logic [WIDTH-1:0] oe_q, iodata_q;
    mode_e            mode_q;

    assign pad_raw[GRP_IN] = in_p2c_i;
    assign pad_raw[GRP_IO] = io_p2c_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int g = 0; g < 2; g++) begin
                for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                    sync_q[g][s] <= '0;
                end
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                sync_q[g][0] <= pad_raw[g];
                for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                    sync_q[g][s] <= sync_q[g][s-1];
                end
            end
        end
    end

    // A bit only flips after the synchronised value has disagreed with it for DEB_CYCLES
    // consecutive cycles; any agreement restarts the count.
    always_comb begin
        for (int g = 0; g < 2; g++) begin
            filt_d[g] = filt_q[g];
            for (int b = 0; b < int'(WIDTH); b++) begin
                cnt_d[g][b] = cnt_q[g][b];
                if (sync_q[g][SYNC_STAGES-1][b] == filt_q[g][b]) begin
                    cnt_d[g][b] = '0;
                end else if (cnt_q[g][b] == CNT_MAX) begin
                    filt_d[g][b] = sync_q[g][SYNC_STAGES-1][b];
                    cnt_d[g][b]  = '0;
                end else begin
                    cnt_d[g][b] = cnt_q[g][b] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int g = 0; g < 2; g++) begin
                filt_q[g] <= '0;
                for (int b = 0; b < int'(WIDTH); b++) begin
                    cnt_q[g][b] <= '0;
                end
            end
            filt_prev_q <= '0;
        end else begin
            for (int g = 0; g < 2; g++) begin
                filt_q[g] <= filt_d[g];
                for (int b = 0; b < int'(WIDTH); b++) begin
                    cnt_q[g][b] <= cnt_d[g][b];
                end
            end
            filt_prev_q <= filt_q[GRP_IN];
        end
    end

    always_comb begin
        out_d = out_q;
        unique case (mode_q)
            ModePass:  out_d = filt_q[GRP_IN];
            ModeLoop:  out_d = filt_q[GRP_IO];
            ModeCount: out_d = out_q + 1'b1;
            ModeHold:  out_d = out_q;
            default:   out_d = out_q;
        endcase
    end

    // A new rising edge beats a software clear of the same bit in the same cycle.
    assign edge_clr  = (cfg_we && cfg_addr == ADDR_EDGE) ? cfg_wdata : '0;
    assign edge_rise = filt_q[GRP_IN] & ~filt_prev_q;
    assign edge_d    = (edge_q & ~edge_clr) | edge_rise;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q    <= '0;
            edge_q   <= '0;
            oe_q     <= '0;
            iodata_q <= '0;
            mode_q   <= ModePass;
        end else begin
            out_q  <= out_d;
            edge_q <= edge_d;
            if (cfg_we) begin
                case (cfg_addr)
                    ADDR_MODE:   mode_q   <= mode_e'(cfg_wdata[1:0]);
                    ADDR_OE:     oe_q     <= cfg_wdata;
                    ADDR_IODATA: iodata_q <= cfg_wdata;
                    default:     ;
                endcase
            end
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            ADDR_MODE:   cfg_rdata = {{(WIDTH-2){1'b0}}, mode_q};
            ADDR_OE:     cfg_rdata = oe_q;
            ADDR_IODATA: cfg_rdata = iodata_q;
            ADDR_EDGE:   cfg_rdata = edge_q;
            default:     cfg_rdata = '0;
        endcase
    end

    assign out_c2p_o = out_q;
    assign io_c2p_o  = iodata_q;
    assign io_oe_o   = oe_q;
    assign edge_o    = edge_q;
    assign irq_o     = |edge_q;

endmodule

// File: tb/tb_pad_io_bank.sv
// Self-checking bench for pad_io_bank: directed scenarios plus randomized traffic, all checked
// every cycle against a history-window reference model.
module tb_pad_io_bank;

    localparam int unsigned WIDTH       = 14;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned DEB_CYCLES  = 4;
    localparam int          HL          = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_we = 1'b0;
    logic [1:0]       cfg_addr = 2'd0;
    logic [WIDTH-1:0] cfg_wdata = '0;
    logic [WIDTH-1:0] in_p2c_i = '0;
    logic [WIDTH-1:0] io_p2c_i = '0;
    logic [WIDTH-1:0] cfg_rdata, out_c2p_o, io_c2p_o, io_oe_o, edge_o;
    logic             irq_o;

    pad_io_bank #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata),
        .in_p2c_i (in_p2c_i),
        .out_c2p_o(out_c2p_o),
        .io_p2c_i (io_p2c_i),
        .io_c2p_o (io_c2p_o),
        .io_oe_o  (io_oe_o),
        .edge_o   (edge_o),
        .irq_o    (irq_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: raw pad history and synchronised history, newest at index 0.
    logic [WIDTH-1:0] h_raw  [2][HL];
    logic [WIDTH-1:0] h_sync [2][HL];
    logic [WIDTH-1:0] m_filt [2];
    logic [WIDTH-1:0] m_fprev, m_out, m_edge, m_oe, m_iod;
    logic [1:0]       m_mode;

    task automatic model_edge(input logic rst, input logic we, input logic [1:0] addr,
                              input logic [WIDTH-1:0] wd, input logic [WIDTH-1:0] inv,
                              input logic [WIDTH-1:0] iov);
        logic [WIDTH-1:0] nf [2];
        logic [WIDTH-1:0] clr;
        logic             flip;
        if (!rst) begin
            for (int g = 0; g < 2; g++) begin
                for (int j = 0; j < HL; j++) begin
                    h_raw[g][j]  = '0;
                    h_sync[g][j] = '0;
                end
                m_filt[g] = '0;
            end
            m_fprev = '0; m_out = '0; m_edge = '0; m_oe = '0; m_iod = '0; m_mode = 2'd0;
            return;
        end
        // A filtered bit flips once the last DEB_CYCLES synchronised samples all oppose it.
        for (int g = 0; g < 2; g++) begin
            for (int b = 0; b < int'(WIDTH); b++) begin
                flip = 1'b1;
                for (int j = 0; j < int'(DEB_CYCLES); j++) begin
                    if (h_sync[g][j][b] == m_filt[g][b]) flip = 1'b0;
                end
                nf[g][b] = m_filt[g][b] ^ flip;
            end
        end
        case (m_mode)
            2'd0: m_out = m_filt[0];
            2'd1: m_out = m_filt[1];
            2'd2: m_out = m_out + 1;
            default: m_out = m_out;
        endcase
        clr    = (we && addr == 2'd3) ? wd : '0;
        m_edge = (m_edge & ~clr) | (m_filt[0] & ~m_fprev);
        if (we) begin
            case (addr)
                2'd0: m_mode = wd[1:0];
                2'd1: m_oe   = wd;
                2'd2: m_iod  = wd;
                default: ;
            endcase
        end
        for (int g = 0; g < 2; g++) begin
            for (int j = HL - 1; j > 0; j--) begin
                h_raw[g][j]  = h_raw[g][j-1];
                h_sync[g][j] = h_sync[g][j-1];
            end
        end
        h_raw[0][0]  = inv;
        h_raw[1][0]  = iov;
        h_sync[0][0] = h_raw[0][SYNC_STAGES-1];
        h_sync[1][0] = h_raw[1][SYNC_STAGES-1];
        m_fprev      = m_filt[0];
        m_filt[0]    = nf[0];
        m_filt[1]    = nf[1];
    endtask

    function automatic logic [WIDTH-1:0] m_rdata(input logic [1:0] a);
        case (a)
            2'd0:    return WIDTH'(m_mode);
            2'd1:    return m_oe;
            2'd2:    return m_iod;
            default: return m_edge;
        endcase
    endfunction

    task automatic tick(input logic rst, input logic we, input logic [1:0] addr,
                        input logic [WIDTH-1:0] wd);
        rst_n     = rst;
        cfg_we    = we;
        cfg_addr  = addr;
        cfg_wdata = wd;
        @(posedge clk);
        model_edge(rst, we, addr, wd, in_p2c_i, io_p2c_i);
        #1;
        cfg_we = 1'b0;
        rst_n  = 1'b1;
        check("out", out_c2p_o, m_out);
        check("io_c2p", io_c2p_o, m_iod);
        check("io_oe", io_oe_o, m_oe);
        check("edge", edge_o, m_edge);
        check("irq", WIDTH'(irq_o), WIDTH'(|m_edge));
        check("rdata", cfg_rdata, m_rdata(cfg_addr));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 2'($urandom_range(0, 3)), '0);
    endtask

    initial begin
        // Reset with all inputs high.
        in_p2c_i = '1;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 2'd0, '0);
        check("rst_out", out_c2p_o, '0);
        check("rst_oe", io_oe_o, '0);
        check("rst_edge", edge_o, '0);
        check("rst_irq", WIDTH'(irq_o), '0);
        check("rst_mode", cfg_rdata, '0);

        // PASS latency: 7 edges from input change to output.
        in_p2c_i = '0;
        idle(10);
        in_p2c_i = 14'h1555;
        for (int i = 1; i <= 6; i++) begin
            tick(1'b1, 1'b0, 2'd0, '0);
            check("lat_out_pre", out_c2p_o, '0);
        end
        tick(1'b1, 1'b0, 2'd0, '0);
        check("lat_out_7", out_c2p_o, 14'h1555);
        check("lat_edge_7", edge_o, 14'h1555);
        check("lat_irq_7", WIDTH'(irq_o), 14'h1);

        // Glitch rejection on bit 3.
        tick(1'b1, 1'b1, 2'd3, '1);
        idle(2);
        in_p2c_i[3] = 1'b1;
        idle(3);
        in_p2c_i[3] = 1'b0;
        idle(12);
        check("glitch3_out", out_c2p_o, 14'h1555);
        check("glitch3_edge", WIDTH'(edge_o[3]), '0);
        in_p2c_i[3] = 1'b1;
        idle(4);
        in_p2c_i[3] = 1'b0;
        idle(12);
        check("pulse4_edge", WIDTH'(edge_o[3]), 14'h1);
        check("pulse4_out", out_c2p_o, 14'h1555);

        // COUNT wrap, then HOLD.
        in_p2c_i = 14'h3FFE;
        idle(12);
        check("cnt_base", out_c2p_o, 14'h3FFE);
        tick(1'b1, 1'b1, 2'd0, 14'd2);
        check("cnt_enter", out_c2p_o, 14'h3FFE);
        tick(1'b1, 1'b0, 2'd0, '0);
        check("cnt_3fff", out_c2p_o, 14'h3FFF);
        tick(1'b1, 1'b0, 2'd0, '0);
        check("cnt_wrap", out_c2p_o, 14'h0000);
        tick(1'b1, 1'b0, 2'd0, '0);
        check("cnt_one", out_c2p_o, 14'h0001);
        tick(1'b1, 1'b1, 2'd0, 14'd3);
        check("hold_mode_rd", cfg_rdata, 14'd3);
        idle(3);
        check("hold_frozen", out_c2p_o, 14'h0002);

        // Clear/set collision on edge bit 0.
        tick(1'b1, 1'b1, 2'd0, 14'd0);
        idle(2);
        tick(1'b1, 1'b1, 2'd3, '1);
        check("coll_cleared", edge_o, '0);
        in_p2c_i[0] = 1'b1;
        idle(7);
        check("coll_first", edge_o, 14'h0001);
        in_p2c_i[0] = 1'b0;
        idle(10);
        in_p2c_i[0] = 1'b1;
        idle(6);
        tick(1'b1, 1'b1, 2'd3, 14'h0001);
        check("coll_setwins", edge_o, 14'h0001);
        idle(3);
        tick(1'b1, 1'b1, 2'd3, 14'h0001);
        check("coll_clr", edge_o, '0);
        check("coll_irq", WIDTH'(irq_o), '0);

        // Inout control and LOOP latency.
        tick(1'b1, 1'b1, 2'd1, 14'h00FF);
        check("oe_wr", io_oe_o, 14'h00FF);
        tick(1'b1, 1'b1, 2'd2, 14'h00A5);
        check("iod_wr", io_c2p_o, 14'h00A5);
        check("oe_keep", io_oe_o, 14'h00FF);
        tick(1'b1, 1'b1, 2'd0, 14'd1);
        tick(1'b1, 1'b0, 2'd0, '0);
        check("loop_zero", out_c2p_o, '0);
        io_p2c_i = 14'h2A5A;
        for (int i = 1; i <= 6; i++) begin
            tick(1'b1, 1'b0, 2'd1, '0);
            check("loop_pre", out_c2p_o, '0);
        end
        tick(1'b1, 1'b0, 2'd1, '0);
        check("loop_7", out_c2p_o, 14'h2A5A);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 1) == 0) in_p2c_i ^= WIDTH'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 1) == 0) io_p2c_i ^= WIDTH'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 599) == 0) begin
                tick(1'b0, 1'b0, 2'd0, '0);
            end else if ($urandom_range(0, 7) == 0) begin
                tick(1'b1, 1'b1, 2'($urandom_range(0, 3)), WIDTH'($urandom));
            end else begin
                tick(1'b1, 1'b0, 2'($urandom_range(0, 3)), '0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
